sass_key_tx: RTL and testbench

Key-event transmitter for the SaSS synth: it watches the 15-bit piano-key vector and emits one byte per key press or release over a byte-wide valid/ready link. It is the sending end of the key interface that `sass_synth` consumes. It sits between the push-button inputs and the board's UART transmit path, so a remote unit can rebuild the live key state from the byte stream. Back-pressure never loses a state change: pending changes merge and are replayed until the stream matches the keys.

---
 rtl/sass_key_tx.sv | 111 +++++++++++
 tb/tb_sass_key_tx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sass_key_tx.sv
// Key-event transmitter: samples the piano-key vector and streams one byte per
// press/release over a valid/ready link, replaying merged changes until in sync.
module sass_key_tx #(
  parameter int SAMPLE_DIV = 1000
) (
  input  logic        hwclk,
  input  logic        n_rst,
  input  logic [14:0] piano_keys,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic [14:0] key_state,
  output logic        busy
);

  localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [14:0]     sync1_q, sync2_q;
  logic [14:0]     smp_q;
  logic [14:0]     rep_q, rep_d;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            wrap;
  logic [14:0]     diff;
  logic            any_diff;
  logic [3:0]      lo_idx;
  logic            lo_val;

  assign wrap = (cnt_q == CW'(SAMPLE_DIV - 1));

  // Lowest differing index wins, so events leave in ascending key order.
  always_comb begin
    diff     = smp_q ^ rep_q;
    any_diff = |diff;
    lo_idx   = 4'd0;
    lo_val   = 1'b0;
    for (int i = 14; i >= 0; i--) begin
      if (diff[i]) begin
        lo_idx = 4'(i);
        lo_val = smp_q[i];
      end
    end
  end

  always_ff @(posedge hwclk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_diff) state_d = SEND;
      SEND:    if (tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The delivered byte, not the current sample, updates the reported state.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    rep_d   = rep_q;
    case (state_q)
      IDLE: begin
        if (any_diff) begin
          data_d  = {lo_val, 3'b000, lo_idx};
          valid_d = 1'b1;
        end
      end
      SEND: begin
        if (tx_ready) begin
          valid_d = 1'b0;
          for (int i = 0; i < 15; i++)
            if (data_q[3:0] == 4'(i)) rep_d[i] = data_q[7];
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge hwclk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      smp_q   <= '0;
      rep_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= piano_keys;
      sync2_q <= sync1_q;
      cnt_q   <= wrap ? '0 : cnt_q + 1'b1;
      if (wrap) smp_q <= sync2_q;
      rep_q   <= rep_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data   = data_q;
  assign tx_valid  = valid_q;
  assign key_state = rep_q;
  assign busy      = valid_q | any_diff;

endmodule

// File: tb/tb_sass_key_tx.sv
// Directed bench for sass_key_tx with SAMPLE_DIV = 4; expected bytes are hand-derived.
module tb_sass_key_tx;

  logic        hwclk;
  logic        n_rst;
  logic [14:0] piano_keys;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [14:0] key_state;
  logic        busy;

  int n_asserts = 0;
  int n_fails   = 0;
  int n;

  sass_key_tx #(.SAMPLE_DIV(4)) dut (
    .hwclk(hwclk), .n_rst(n_rst), .piano_keys(piano_keys), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .key_state(key_state), .busy(busy)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hwclk);
    #1;
  endtask

  // Returns number of edges until tx_valid is seen, or -1 on timeout.
  task automatic wait_valid(output int cnt);
    cnt = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (tx_valid === 1'b1) begin
        cnt = k;
        break;
      end
    end
  endtask

  // Expects one byte with tx_ready high: found, value, then valid drops after handshake.
  task automatic get_byte(input logic [7:0] exp, input string tag, output int cnt);
    wait_valid(cnt);
    chk({tag, "_seen"}, 32'(cnt > 0), 32'd1);
    chk({tag, "_data"}, 32'(tx_data), 32'(exp));
    step();
    chk({tag, "_drop"}, 32'(tx_valid), 32'd0);
  endtask

  initial begin
    n_rst      = 1'b0;
    piano_keys = 15'h7FFF;
    tx_ready   = 1'b1;

    // Reset with all keys held
    step(); step();
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data",  32'(tx_data), 32'h00);
    chk("rst_keys",  32'(key_state), 32'h0);
    chk("rst_busy",  32'(busy), 32'd0);
    n_rst = 1'b1;
    get_byte(8'h80, "rel_first", n);
    chk("rel_first_latency", 32'(n), 32'd5);
    for (int i = 1; i < 15; i++) begin
      get_byte(8'h80 | 8'(i), "rel_press", n);
      chk("rel_press_spacing", 32'(n), 32'd1);
    end
    chk("rel_keys_all", 32'(key_state), 32'h7FFF);
    chk("rel_busy_idle", 32'(busy), 32'd0);

    // Release everything: ascending release bytes
    piano_keys = 15'h0000;
    for (int i = 0; i < 15; i++) get_byte(8'(i), "bulk_release", n);
    chk("bulk_keys_clear", 32'(key_state), 32'h0);

    // Single key 3
    piano_keys = 15'h0008;
    get_byte(8'h83, "k3_press", n);
    chk("k3_state_set", 32'(key_state), 32'h0008);
    piano_keys = 15'h0000;
    get_byte(8'h03, "k3_release", n);
    chk("k3_state_clr", 32'(key_state), 32'h0000);

    // Glitch: release byte was loaded one edge after a wrap, so the pulse
    // seen at the next two edges sits strictly between sampled edges.
    step();
    piano_keys = 15'h0080;
    step(); step();
    piano_keys = 15'h0000;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("glitch_busy",  32'(busy), 32'd0);
      chk("glitch_valid", 32'(tx_valid), 32'd0);
    end

    // Simultaneous keys 0 and 14
    piano_keys = 15'h4001;
    get_byte(8'h80, "sim_k0", n);
    get_byte(8'h8E, "sim_k14", n);
    chk("sim_one_idle", 32'(n), 32'd1);
    chk("sim_state", 32'(key_state), 32'h4001);
    piano_keys = 15'h0000;
    get_byte(8'h00, "sim_rel0", n);
    get_byte(8'h0E, "sim_rel14", n);

    // Back-pressure on key 5 with release during the stall
    tx_ready   = 1'b0;
    piano_keys = 15'h0020;
    wait_valid(n);
    chk("bp_seen", 32'(n > 0), 32'd1);
    for (int k = 0; k < 50; k++) begin
      if (k == 20) piano_keys = 15'h0000;
      chk("bp_stable_valid", 32'(tx_valid), 32'd1);
      chk("bp_stable_data",  32'(tx_data), 32'h85);
      step();
    end
    chk("bp_busy", 32'(busy), 32'd1);
    tx_ready = 1'b1;
    step();
    chk("bp_hs_drop", 32'(tx_valid), 32'd0);
    chk("bp_hs_state", 32'(key_state), 32'h0020);
    get_byte(8'h05, "bp_release", n);
    chk("bp_final_state", 32'(key_state), 32'h0000);

    // Mid-operation reset while stalled in SEND
    piano_keys = 15'h0004;
    get_byte(8'h82, "mr_k2", n);
    tx_ready   = 1'b0;
    piano_keys = 15'h0204;
    wait_valid(n);
    chk("mr_pending", 32'(tx_data), 32'h89);
    step(); step();
    n_rst = 1'b0;
    #1;
    chk("mr_async_valid", 32'(tx_valid), 32'd0);
    chk("mr_async_keys",  32'(key_state), 32'h0);
    chk("mr_async_busy",  32'(busy), 32'd0);
    step();
    tx_ready = 1'b1;
    n_rst    = 1'b1;
    get_byte(8'h82, "mr_resend_k2", n);
    chk("mr_resend_latency", 32'(n), 32'd5);
    get_byte(8'h89, "mr_resend_k9", n);
    chk("mr_final_state", 32'(key_state), 32'h0204);
    chk("mr_final_busy",  32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
